// File: rtl/gf_addsub_serial_pkg.sv
// Shared types and defaults for the limb-serial GF(p) add/subtract unit.
// Optional feature macro: GF_ADDSUB_NEG_EN (enables op 2'b10 = NEG).
package gf_pkg;

  localparam int GF_WIDTH = 256;
  localparam int GF_LIMB  = 64;

  typedef enum logic [1:0] {
    GF_ADD = 2'd0,
    GF_SUB = 2'd1,
    GF_NEG = 2'd2
  } gf_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } gf_state_t;

  // Map a raw op code to the operation actually performed; reserved codes run as ADD.
  function automatic gf_op_t gf_decode_op(input logic [1:0] op_raw);
    gf_op_t op_dec;
    case (op_raw)
      2'b01:   op_dec = GF_SUB;
`ifdef GF_ADDSUB_NEG_EN
      2'b10:   op_dec = GF_NEG;
`endif
      default: op_dec = GF_ADD;
    endcase
    return op_dec;
  endfunction

endpackage

// File: rtl/gf_addsub_serial_if.sv
// Operand/result handshake bundle for gf_addsub_serial.
// Optional feature macro: GF_ADDSUB_NEG_EN (affects only the meaning of op).
interface gf_addsub_serial_if #(
  parameter int WIDTH = gf_pkg::GF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] p;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op, a, b, p, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, p, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/gf_addsub_serial_limb_adder.sv
// One LIMB-wide ripple adder slice, reused every cycle by gf_addsub_serial.
// Optional feature macro: GF_ADDSUB_NEG_EN (not used here).
module limb_adder #(
  parameter int LIMB = gf_pkg::GF_LIMB
) (
  input  logic [LIMB-1:0] x,
  input  logic [LIMB-1:0] y,
  input  logic            cin,
  output logic [LIMB-1:0] sum,
  output logic            cout
);

  // Full-width add with carry in; top bit of the widened sum is the carry out.
  always_comb begin
    {cout, sum} = {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, cin};
  end

endmodule

// File: rtl/gf_addsub_serial.sv
// Limb-serial modular add/subtract over GF(p): pass 1 forms a+b or a-b,
// pass 2 forms the p-corrected value, and the correct one is picked at the end.
// Optional feature macro: GF_ADDSUB_NEG_EN (op 2'b10 computes (p-b) mod p).
module gf_addsub_serial
  import gf_pkg::*;
#(
  parameter int WIDTH = GF_WIDTH,
  parameter int LIMB  = GF_LIMB
) (
  input  logic               clk,
  input  logic               rst,
  gf_addsub_serial_if.slave  bus
);

  localparam int NLIMB = WIDTH / LIMB;
  localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  gf_state_t        state_r;
  gf_op_t           op_r;
  logic [WIDTH-1:0] a_r, b_r, p_r, s_r, t_r, result_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r, c1_r, bw1_r;
  logic             in_ready_r, out_valid_r, busy_r;
`ifdef GF_ADDSUB_NEG_EN
  logic             b_zero_r;
`endif

  logic [LIMB-1:0]  x_s, y_s, sum_s;
  logic             cout_s, last_s;
  logic [WIDTH-1:0] t_full_s, s_full_s, sel_s;
  gf_op_t           op_dec_s;

  assign op_dec_s      = gf_decode_op(bus.op);
  assign last_s        = (cnt_r == CW'(NLIMB - 1));
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.busy      = busy_r;

  // Adder operands: pass 1 adds a and b (b inverted for SUB/NEG), pass 2 corrects by p.
  always_comb begin
    x_s = a_r[LIMB-1:0];
    y_s = b_r[LIMB-1:0];
    if (state_r == PASS2) begin
      x_s = s_r[LIMB-1:0];
      y_s = (op_r == GF_ADD) ? ~p_r[LIMB-1:0] : p_r[LIMB-1:0];
    end else begin
      y_s = (op_r == GF_ADD) ? b_r[LIMB-1:0] : ~b_r[LIMB-1:0];
    end
  end

  limb_adder #(.LIMB(LIMB)) u_adder (
    .x    (x_s),
    .y    (y_s),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Final selection on the last pass-2 limb; cout_s there is the inverse of the pass-2 borrow.
  always_comb begin
    t_full_s = {sum_s, t_r[WIDTH-1:LIMB]};
    s_full_s = {s_r[LIMB-1:0], s_r[WIDTH-1:LIMB]};
    sel_s    = s_full_s;
    case (op_r)
      GF_SUB:  sel_s = bw1_r ? t_full_s : s_full_s;
`ifdef GF_ADDSUB_NEG_EN
      GF_NEG:  sel_s = b_zero_r ? {WIDTH{1'b0}} : s_full_s;
`endif
      default: sel_s = (c1_r | cout_s) ? t_full_s : s_full_s;
    endcase
  end

  // Control FSM with limb shifters and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      op_r        <= GF_ADD;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      p_r         <= {WIDTH{1'b0}};
      s_r         <= {WIDTH{1'b0}};
      t_r         <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      carry_r     <= 1'b0;
      c1_r        <= 1'b0;
      bw1_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef GF_ADDSUB_NEG_EN
      b_zero_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            op_r       <= op_dec_s;
            a_r        <= bus.a;
`ifdef GF_ADDSUB_NEG_EN
            if (op_dec_s == GF_NEG) a_r <= bus.p;
            b_zero_r   <= (bus.b == {WIDTH{1'b0}});
`endif
            b_r        <= bus.b;
            p_r        <= bus.p;
            // Subtraction-style ops start with carry 1 to complete the two's complement of b.
            carry_r    <= (op_dec_s != GF_ADD);
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= PASS1;
          end
        end
        PASS1: begin
          a_r     <= {{LIMB{1'b0}}, a_r[WIDTH-1:LIMB]};
          b_r     <= {{LIMB{1'b0}}, b_r[WIDTH-1:LIMB]};
          s_r     <= {sum_s, s_r[WIDTH-1:LIMB]};
          carry_r <= cout_s;
          cnt_r   <= last_s ? {CW{1'b0}} : cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            c1_r    <= cout_s;
            bw1_r   <= ~cout_s;
            // Pass 2 subtracts p for ADD (carry-in 1) and adds p otherwise (carry-in 0).
            carry_r <= (op_r == GF_ADD);
            state_r <= PASS2;
          end
        end
        PASS2: begin
          // S and p rotate so both are back in original order after the pass.
          s_r     <= {s_r[LIMB-1:0], s_r[WIDTH-1:LIMB]};
          p_r     <= {p_r[LIMB-1:0], p_r[WIDTH-1:LIMB]};
          t_r     <= t_full_s;
          carry_r <= cout_s;
          cnt_r   <= last_s ? {CW{1'b0}} : cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            result_r    <= sel_s;
            out_valid_r <= 1'b1;
            carry_r     <= 1'b0;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_addsub_serial.sv
// Self-checking bench for gf_addsub_serial at WIDTH=256, LIMB=64.
// Optional feature macro: GF_ADDSUB_NEG_EN (selects NEG vs reserved-op checks).
module tb_gf_addsub_serial;

  localparam int W     = 256;
  localparam int L     = 64;
  localparam int NL    = W / L;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  gf_addsub_serial_if #(.WIDTH(W)) bus ();

  gf_addsub_serial #(.WIDTH(W), .LIMB(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to time accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: modular arithmetic straight from the operation definitions.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] p);
    logic [W:0] s;
    if (op == 2'd1) return (a >= b) ? a - b : p - (b - a);
`ifdef GF_ADDSUB_NEG_EN
    if (op == 2'd2) return (b == '0) ? '0 : p - b;
`endif
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Present an operand set and return right after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] p);
    int n;
    bus.op = op; bus.a = a; bus.b = b; bus.p = p;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_timeout", {255'd0, (n < 50)}, {255'd0, 1'b1});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid, checking busy/in_ready in flight; lat = edges after accept.
  task automatic wait_done(output int lat);
    logic ok;
    ok  = 1'b1;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (bus.busy !== 1'b1) ok = 1'b0;
    chk("busy_in_flight", {255'd0, ok}, {255'd0, 1'b1});
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_out_valid", {255'd0, bus.out_valid}, '0);
    chk("post_hs_in_ready", {255'd0, bus.in_ready}, {255'd0, 1'b1});
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] p);
    int lat;
    bus.out_ready = 1'b0;
    issue(op, a, b, p);
    wait_done(lat);
    // Out_valid appears 2*NLIMB edges after the accept edge: the 9th cycle counting the accept cycle.
    chk({tag, "_latency"}, W'(lat), W'(2 * NL));
    chk({tag, "_result"}, bus.result, model(op, a, b, p));
    handshake();
  endtask

  initial begin
    logic [W-1:0] p25519, one, pr, ar, br;
    logic [1:0]   opr;
    int           lat;
    int           acc [3];
    logic [W-1:0] ba [3], bb [3];
    logic [W-1:0] held;
    logic         stable;

    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 2'd0;
    bus.a = '0; bus.b = '0; bus.p = '0;
    one = 256'd1;
    p25519 = (one << 255) - 256'd19;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {255'd0, bus.in_ready}, {255'd0, 1'b1});
    chk("rst_out_valid", {255'd0, bus.out_valid}, '0);
    chk("rst_busy", {255'd0, bus.busy}, '0);
    chk("rst_result", bus.result, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed small-prime cases.
    do_op("add_wrap", 2'd0, 256'hFFF0, 256'h0005, 256'hFFF1);
    chk("add_wrap_exact", bus.result, 256'h0004);
    do_op("sub_borrow", 2'd1, 256'h0003, 256'h0007, 256'hFFF1);
    chk("sub_borrow_exact", bus.result, 256'hFFED);
    do_op("sub_equal", 2'd1, 256'h1234, 256'h1234, 256'hFFF1);
    do_op("add_eq_p", 2'd0, 256'h0FF1, 256'hF000, 256'hFFF1);
    chk("add_eq_p_zero", bus.result, '0);
    do_op("reserved3", 2'd3, 256'h0001, 256'h0002, 256'hFFF1);
`ifdef GF_ADDSUB_NEG_EN
    do_op("neg_one", 2'd2, 256'h0, 256'h0001, 256'hFFF1);
    chk("neg_one_exact", bus.result, 256'hFFF0);
    do_op("neg_zero", 2'd2, 256'h0, 256'h0000, 256'hFFF1);
    chk("neg_zero_exact", bus.result, '0);
`else
    do_op("op2_as_add", 2'd2, 256'h0001, 256'h0002, 256'hFFF1);
    chk("op2_as_add_exact", bus.result, 256'h0003);
`endif

    // Full-width overflow through c1, with output stall.
    bus.out_ready = 1'b0;
    issue(2'd0, p25519 - one, p25519 - one, p25519);
    wait_done(lat);
    chk("c1_result", bus.result, p25519 - 256'd2);
    held = bus.result;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== held) stable = 1'b0;
    end
    chk("stall_stable", {255'd0, stable}, {255'd1});
    handshake();

    // Reset during pass 2 aborts asynchronously.
    issue(2'd0, 256'h5, 256'h6, 256'hFFF1);
    repeat (NL + 1) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {255'd0, bus.out_valid}, '0);
    chk("arst_in_ready", {255'd0, bus.in_ready}, {255'd0, 1'b1});
    chk("arst_busy", {255'd0, bus.busy}, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    do_op("after_rst", 2'd0, 256'h1, 256'h2, 256'hFFF1);
    chk("after_rst_exact", bus.result, 256'h3);

    // Randomized ops against the reference model.
    for (int k = 0; k < 10; k++) begin
      pr = rand_w() >> $urandom_range(0, 250);
      pr[0] = 1'b1;
      if (pr < 256'd3) pr = 256'd5;
      ar = rand_w() % pr;
      br = (k == 3) ? ar : rand_w() % pr;
      opr = 2'($urandom_range(0, 3));
      do_op("rand", opr, ar, br, pr);
    end

    // Back-to-back: in_valid held high, out_ready tied high.
    for (int k = 0; k < 3; k++) begin
      ba[k] = rand_w() % p25519;
      bb[k] = rand_w() % p25519;
    end
    bus.out_ready = 1'b1;
    bus.op = 2'd1; bus.p = p25519; bus.a = ba[0]; bus.b = bb[0];
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      while (bus.in_ready !== 1'b1 && lat < 50) begin
        @(posedge clk); #1; lat++;
      end
      chk("b2b_accept_timeout", {255'd0, (lat < 50)}, {255'd0, 1'b1});
      @(posedge clk);
      acc[k] = cyc;
      #1;
      if (k < 2) begin bus.a = ba[k+1]; bus.b = bb[k+1]; end
      wait_done(lat);
      chk("b2b_result", bus.result, model(2'd1, ba[k], bb[k], p25519));
      if (k > 0) chk("b2b_spacing", W'(acc[k] - acc[k-1]), W'(2 * NL + 2));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", {255'd0, bus.in_ready}, {255'd0, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
